// File: rtl/i_type_pkg.sv
// i_type_pkg: shared definitions for the I-type issue path.
//   - instruction field bit positions
//   - the eight supported I-type opcodes
//   - issue FSM state encoding
//   - is_legal(): opcode legality helper
package i_type_pkg;

  localparam int unsigned INST_W = 32;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_OPND = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  function automatic logic is_legal(input logic [5:0] opc);
    return opc inside {OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
                       OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI};
  endfunction

endpackage

// File: rtl/i_type_decode.sv
// i_type_decode: combinational I-type field extraction.
//   inst  : instruction word
//   rs    : source register field
//   rt    : destination register field
//   imm   : raw 16-bit immediate
//   legal : opcode is one of the supported I-type ops
module i_type_decode
  import i_type_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [15:0]       imm,
  output logic              legal
);

  always_comb begin
    rs    = inst[RS_HI:RS_LO];
    rt    = inst[RT_HI:RT_LO];
    imm   = inst[IMM_HI:IMM_LO];
    legal = is_legal(inst[OPC_HI:OPC_LO]);
  end

endmodule

// File: rtl/i_type_issue.sv
// i_type_issue: issues one I-type instruction at a time to the I-type ALU
// and forwards its result to the register-file write port.
//   clk, rst              : clock, synchronous active-high reset
//   inst_valid/data/ready : instruction handshake from fetch
//   rf_rd_en/addr/data    : rs read port (data one cycle after rf_rd_en)
//   alu_inst/i1/i2        : instruction, operand and raw immediate to the ALU
//   alu_out               : combinational ALU result
//   wb_valid/addr/data/ready : rt write-back handshake
//   illegal               : one-cycle pulse after accepting a bad opcode
module i_type_issue
  import i_type_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic [31:0]       inst_data,
  output logic              inst_ready,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [31:0]       alu_inst,
  output logic [DATA_W-1:0] alu_i1,
  output logic [IMM_W-1:0]  alu_i2,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  output logic              illegal
);

  state_t      state;
  logic [31:0] dec_in;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [15:0] dec_imm;
  logic        dec_legal;

  // One decoder serves both phases: in IDLE it looks at the offered word
  // (legality, immediate), afterwards at the held instruction (rs, rt).
  assign dec_in = (state == S_IDLE) ? inst_data : alu_inst;

  i_type_decode u_decode (
    .inst  (dec_in),
    .rs    (dec_rs),
    .rt    (dec_rt),
    .imm   (dec_imm),
    .legal (dec_legal)
  );

  always_comb begin
    inst_ready = (state == S_IDLE);
    rf_rd_en   = (state == S_RD) && (dec_rs != 5'd0);
    rf_rd_addr = rf_rd_en ? REG_AW'(dec_rs) : '0;
    wb_valid   = (state == S_WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      alu_inst <= '0;
      alu_i1   <= '0;
      alu_i2   <= '0;
      wb_addr  <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_valid) begin
            alu_inst <= inst_data;
            alu_i2   <= IMM_W'(dec_imm);
            if (dec_legal) state   <= S_RD;
            else           illegal <= 1'b1;
          end
        end
        S_RD:   state <= S_OPND;
        S_OPND: begin
          alu_i1 <= (dec_rs == 5'd0) ? '0 : rf_rd_data;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          wb_data <= alu_out;
          wb_addr <= REG_AW'(dec_rt);
          state   <= (dec_rt == 5'd0) ? S_IDLE : S_WB;
        end
        S_WB:    if (wb_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
